// File: rtl/axis_pkg.sv
// Shared AXI-stream definitions: arbitration modes, arbiter states, counter width
// and the tuser width helper used by the fan-in blocks.
package axis_pkg;

  localparam int ARB_PRIORITY    = 0;
  localparam int ARB_ROUND_ROBIN = 1;
  localparam int PKTCNT_W        = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Index width for n channels, never narrower than one bit.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-stream output stage: a registered output plus one skid entry so the
// upstream ready depends only on local state and full throughput is kept.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_load_i,   // beat accepted upstream this cycle
  output logic         in_rdy_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_data_o
);

  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;

  // Ready is forced low while reset is held so nothing is accepted in reset.
  assign in_rdy_o   = rst_ni & ~skid_vld_q;
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!out_vld_q || out_rdy_i) begin
      // Skid is older than any incoming beat, so it always moves up first.
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_load_i) begin
        out_d     = in_data_i;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_load_i) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/axis_arb_fan_in.sv
// N:1 AXI-stream fan-in: priority or round-robin arbitration, optional packet lock
// on tlast, registered output. Per-channel packet counters under AXIS_ARB_FAN_IN_PKTCNT_EN.
module axis_arb_fan_in
  import axis_pkg::*;
#(
  parameter int NUM_FANIN      = 6,
  parameter int DATA_WIDTH     = 128,
  parameter int USE_AXIS_TLAST = 1,
  parameter int ARB_MODE       = 1,
  localparam int CW            = cw_of(NUM_FANIN)
) (
  input  logic                            s_axis_clk,
  input  logic                            s_axis_rstn,
  input  logic [NUM_FANIN-1:0]            s_axis_tvalid,
  output logic [NUM_FANIN-1:0]            s_axis_tready,
  input  logic [NUM_FANIN*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_FANIN-1:0]            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [CW-1:0]                   m_axis_tuser
`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
  ,
  output logic [NUM_FANIN*PKTCNT_W-1:0]   pkt_count
`endif
);

  localparam int PW = DATA_WIDTH + CW + 1;

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         lock_chan_q, lock_chan_d;
  logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         gnt;
  logic                  gnt_vld;
  logic                  in_ready;
  logic                  accept;
  logic                  sel_last, last_eff;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PW-1:0]         out_payload;
  int                    idx;

  // Grant selection; a lock pins the grant regardless of other valids.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (state_q == ARB_LOCKED) begin
      gnt     = lock_chan_q;
      gnt_vld = s_axis_tvalid[lock_chan_q];
    end else if (ARB_MODE == ARB_PRIORITY) begin
      for (int i = 0; i < NUM_FANIN; i++) begin
        if (s_axis_tvalid[i]) begin
          gnt     = CW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_FANIN; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_FANIN) idx = idx - NUM_FANIN;
        if (!gnt_vld && s_axis_tvalid[idx]) begin
          gnt     = CW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_FANIN; i++) begin
      if (gnt == CW'(i)) begin
        sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = s_axis_tlast[i];
      end
    end
  end

  // Without tlast support every beat is a complete packet.
  assign last_eff = (USE_AXIS_TLAST != 0) ? sel_last : 1'b1;
  assign accept   = gnt_vld & in_ready;

  always_comb begin
    s_axis_tready = '0;
    if (accept) s_axis_tready[gnt] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && !last_eff) begin
          state_d     = ARB_LOCKED;
          lock_chan_d = gnt;
        end
      end
      ARB_LOCKED: begin
        if (accept && last_eff) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (ARB_MODE == ARB_ROUND_ROBIN && accept && last_eff)
      rr_ptr_d = (gnt == CW'(NUM_FANIN - 1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      state_q     <= ARB_IDLE;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  axis_skid_reg #(
    .W (PW)
  ) u_out (
    .clk_i      (s_axis_clk),
    .rst_ni     (s_axis_rstn),
    .in_load_i  (accept),
    .in_rdy_o   (in_ready),
    .in_data_i  ({last_eff, gnt, sel_data}),
    .out_vld_o  (m_axis_tvalid),
    .out_rdy_i  (m_axis_tready),
    .out_data_o (out_payload)
  );

  assign m_axis_tdata = out_payload[DATA_WIDTH-1:0];
  assign m_axis_tuser = out_payload[DATA_WIDTH +: CW];
  assign m_axis_tlast = out_payload[PW-1];

`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
  logic [NUM_FANIN-1:0][PKTCNT_W-1:0] cnt_q;

  for (genvar c = 0; c < NUM_FANIN; c++) begin : g_cnt
    logic [PKTCNT_W-1:0] cnt_d;

    // Saturating: stops at all-ones instead of wrapping.
    always_comb begin
      cnt_d = cnt_q[c];
      if (accept && last_eff && gnt == CW'(c) && cnt_q[c] != '1)
        cnt_d = cnt_q[c] + 1'b1;
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
      if (!s_axis_rstn) cnt_q[c] <= '0;
      else              cnt_q[c] <= cnt_d;
    end

    assign pkt_count[c*PKTCNT_W +: PKTCNT_W] = cnt_q[c];
  end
`endif

endmodule

// File: tb/tb_axis_arb_fan_in.sv
// Bench for axis_arb_fan_in: a round-robin and a fixed-priority instance share stimulus;
// expected output streams come from a packet-level arbitration model.
module tb_axis_arb_fan_in;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [1:0]    u;
    logic [DW-1:0] d;
    logic          l;
  } out_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    tvalid;
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tlast;
  logic            m_ready;

  logic [N-1:0]  rr_tready, pr_tready, v_tready;
  logic          rr_mvalid, pr_mvalid, v_mvalid;
  logic [DW-1:0] rr_mdata, pr_mdata, v_mdata;
  logic          rr_mlast, pr_mlast, v_mlast;
  logic [1:0]    rr_muser, pr_muser, v_muser;
`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
  logic [N*16-1:0] rr_cnt, pr_cnt;
`endif

  bit   sel_pri;
  out_t v_pl;

  always #5 clk = ~clk;

  axis_arb_fan_in #(.NUM_FANIN(N), .DATA_WIDTH(DW), .USE_AXIS_TLAST(1), .ARB_MODE(1)) dut_rr (
    .s_axis_clk(clk), .s_axis_rstn(rstn), .s_axis_tvalid(tvalid), .s_axis_tready(rr_tready),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .m_axis_tvalid(rr_mvalid), .m_axis_tready(m_ready),
    .m_axis_tdata(rr_mdata), .m_axis_tlast(rr_mlast), .m_axis_tuser(rr_muser)
`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
    , .pkt_count(rr_cnt)
`endif
  );

  axis_arb_fan_in #(.NUM_FANIN(N), .DATA_WIDTH(DW), .USE_AXIS_TLAST(1), .ARB_MODE(0)) dut_pr (
    .s_axis_clk(clk), .s_axis_rstn(rstn), .s_axis_tvalid(tvalid), .s_axis_tready(pr_tready),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .m_axis_tvalid(pr_mvalid), .m_axis_tready(m_ready),
    .m_axis_tdata(pr_mdata), .m_axis_tlast(pr_mlast), .m_axis_tuser(pr_muser)
`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
    , .pkt_count(pr_cnt)
`endif
  );

  always_comb begin
    v_tready = sel_pri ? pr_tready : rr_tready;
    v_mvalid = sel_pri ? pr_mvalid : rr_mvalid;
    v_mdata  = sel_pri ? pr_mdata  : rr_mdata;
    v_mlast  = sel_pri ? pr_mlast  : rr_mlast;
    v_muser  = sel_pri ? pr_muser  : rr_muser;
    v_pl     = '{u: v_muser, d: v_mdata, l: v_mlast};
  end

  int compared   = 0;
  int mismatched = 0;

  beat_t pk [N][64];
  int    nb [N];
  int    hd [N];
  out_t  expq [$];
  int    first_acc, first_out, last_out, nout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      nb[c] = 0;
      hd[c] = 0;
    end
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int b = 0; b < len; b++) begin
      if (nb[c] < 64) begin
        pk[c][nb[c]] = '{d: $urandom, l: (b == len - 1)};
        nb[c]++;
      end
    end
  endtask

  // Packet-level model: pick a channel by the arbitration rule, emit its whole packet.
  task automatic build_exp(input bit pri);
    int h [N];
    int ptr, c;
    bit done;
    expq.delete();
    ptr = 0;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    forever begin
      c = -1;
      if (pri) begin
        for (int i = 0; i < N; i++) if (h[i] < nb[i]) c = i;
      end else begin
        for (int k = 0; k < N; k++)
          if (c < 0 && h[(ptr + k) % N] < nb[(ptr + k) % N]) c = (ptr + k) % N;
      end
      if (c < 0) break;
      done = 1'b0;
      while (!done) begin
        expq.push_back('{u: 2'(c), d: pk[c][h[c]].d, l: pk[c][h[c]].l});
        done = pk[c][h[c]].l;
        h[c]++;
        if (h[c] >= nb[c]) done = 1'b1;
      end
      ptr = (c + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn   = 1'b0;
    tvalid = '1;
    #1;
    chk("rst_tready", 64'(v_tready), 64'd0);
    chk("rst_mvalid", 64'(v_mvalid), 64'd0);
    chk("rst_payload", 64'(v_pl), 64'd0);
    @(negedge clk);
    tvalid = '0;
    rstn   = 1'b1;
  endtask

  // mrmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. stop_after>0 returns after that many accepts.
  task automatic run(input int mrmode, input int stop_after, input int max_cyc);
    logic [3:0] pat = 4'b1001;
    logic [N-1:0] acc;
    out_t held, e;
    bit   holding = 1'b0;
    int   mid = -1;
    int   acc_cnt = 0;
    bit   fin = 1'b0;
    build_exp(sel_pri);
    first_acc = -1; first_out = -1; last_out = -1; nout = 0;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (hd[c] < nb[c]) begin
          tvalid[c]           = 1'b1;
          tdata[c*DW +: DW]   = pk[c][hd[c]].d;
          tlast[c]            = pk[c][hd[c]].l;
        end else begin
          tvalid[c]           = 1'b0;
          tdata[c*DW +: DW]   = $urandom;
          tlast[c]            = 1'($urandom);
        end
      end
      m_ready = (mrmode == 0) ? 1'b1 : (mrmode == 1) ? pat[cyc % 4] : 1'($urandom);
      #1;
      chk("tready_onehot", 64'($onehot0(v_tready)), 64'd1);
      if (mid >= 0) chk("lock_excl", 64'(v_tready & ~(N'(1) << mid)), 64'd0);
      if (holding) chk("stall_stable", 64'({v_mvalid, v_pl}), 64'({1'b1, held}));
      acc = v_tready & tvalid;
      if (v_mvalid && m_ready) begin
        if (expq.size() == 0) chk("extra_out", 64'(v_pl), 64'd0 - 1);
        else begin
          e = expq.pop_front();
          chk("out_beat", 64'(v_pl), 64'(e));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        nout++;
      end
      holding = v_mvalid & ~m_ready;
      held    = v_pl;
      @(posedge clk);
      for (int c = 0; c < N; c++) begin
        if (acc[c]) begin
          if (first_acc < 0) first_acc = cyc;
          mid = pk[c][hd[c]].l ? -1 : c;
          hd[c]++;
          acc_cnt++;
        end
      end
      if (stop_after > 0 && acc_cnt >= stop_after) fin = 1'b1;
      if (stop_after == 0 && expq.size() == 0) fin = 1'b1;
    end
    if (stop_after == 0) chk("drained", 64'(expq.size()), 64'd0);
    else chk("accepts_reached", 64'(acc_cnt >= stop_after), 64'd1);
  endtask

  initial begin
    rstn    = 1'b0;
    tvalid  = '0;
    tdata   = '0;
    tlast   = '0;
    m_ready = 1'b0;
    sel_pri = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    do_reset();
    sel_pri = 1'b1;
    #1;
    chk("rst_tready_pri", 64'(v_tready), 64'd0);
    chk("rst_mvalid_pri", 64'(v_mvalid), 64'd0);

    // Fixed priority: channels 0 and 2 pending, channel 2 must win.
    sel_pri = 1'b1;
    clr(); add_pkt(0, 1); add_pkt(2, 1);
    run(0, 0, 50);

    // Round-robin streaming single beats: 0,1,2,3,... one per clock.
    sel_pri = 1'b0;
    do_reset();
    clr();
    for (int c = 0; c < N; c++) for (int p = 0; p < 8; p++) add_pkt(c, 1);
    run(0, 0, 200);
    chk("rr_latency", 64'(first_out - first_acc), 64'd1);
    chk("rr_throughput", 64'(last_out - first_out + 1), 64'(nout));
    chk("rr_count", 64'(nout), 64'(4 * 8));

    // Packet lock: channel 1 three beats, channel 3 waiting.
    do_reset();
    clr(); add_pkt(1, 3); add_pkt(3, 1);
    run(0, 0, 50);

    // Backpressure pattern 1,0,0,1 with random packets, round-robin.
    do_reset();
    clr();
    for (int c = 0; c < N; c++) for (int p = 0; p < 5; p++) add_pkt(c, $urandom_range(1, 4));
    run(1, 0, 2000);

    // Random backpressure, priority instance.
    sel_pri = 1'b1;
    do_reset();
    clr();
    for (int c = 0; c < N; c++) for (int p = 0; p < 4; p++) add_pkt(c, $urandom_range(1, 3));
    run(2, 0, 2000);

    // Reset in the middle of a 4-beat packet on channel 2.
    sel_pri = 1'b0;
    do_reset();
    clr(); add_pkt(1, 1); add_pkt(2, 4);
    run(0, 3, 50);
    do_reset();
    clr(); add_pkt(0, 1); add_pkt(3, 1);
    run(0, 0, 50);
    chk("post_rst_count", 64'(nout), 64'd2);

`ifdef AXIS_ARB_FAN_IN_PKTCNT_EN
    do_reset();
    @(negedge clk);
    tvalid  = 4'b0001;
    tlast   = '1;
    m_ready = 1'b1;
    repeat (70000) @(negedge clk);
    tvalid = '0;
    @(negedge clk);
    chk("cnt_sat_rr", 64'(rr_cnt[15:0]), 64'hFFFF);
    chk("cnt_sat_pr", 64'(pr_cnt[15:0]), 64'hFFFF);
    chk("cnt_others", 64'(rr_cnt[N*16-1:16]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
